// File: rtl/dmem_result_monitor_if.sv
// CPU data-memory write port as seen by the result monitor.
// The CPU side drives it; the monitor only snoops.
interface dmem_result_monitor_if;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;

  modport master (
    output d_mem_addr,
    output d_mem_wdata,
    output d_mem_wen
  );

  modport slave (
    input d_mem_addr,
    input d_mem_wdata,
    input d_mem_wen
  );
endinterface

// File: rtl/dmem_result_monitor.sv
// Snoops CPU word stores into a result window and checks them against
// preloaded expected values once the program writes its completion flag.
module dmem_result_monitor #(
  parameter int          RESULT_BASE    = 512,
  parameter int          NUM_RESULTS    = 6,
  parameter int          IDX_W          = 3,
  parameter int          DONE_ADDR      = 768,
  parameter logic [31:0] DONE_VALUE     = 32'h1,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmem_result_monitor_if.slave   bus,
  input  logic                   exp_wr_en,
  input  logic [IDX_W-1:0]       exp_wr_idx,
  input  logic [31:0]            exp_wr_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_data,
  output logic [NUM_RESULTS-1:0] captured_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [IDX_W:0]         fail_count,
  output logic [IDX_W-1:0]       first_fail_idx,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam logic [31:0]      BASE    = 32'(RESULT_BASE);
  localparam logic [31:0]      SPAN    = 32'(4 * NUM_RESULTS);
  localparam logic [31:0]      DADDR   = 32'(DONE_ADDR);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]   NUM     = (IDX_W + 1)'(NUM_RESULTS);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_RESULTS - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]            res  [NUM_RESULTS];
  logic [31:0]            expv [NUM_RESULTS];
  logic [NUM_RESULTS-1:0] mask;
  logic [IDX_W-1:0]       chk_idx;
  logic [IDX_W:0]         fails;
  logic [IDX_W-1:0]       first;
  logic                   to_flag;
  logic [CNT_W-1:0]       cyc_cnt;

  logic [31:0]      off;
  logic             full;
  logic             in_win;
  logic [IDX_W-1:0] slot;
  logic             done_st;
  logic             to_hit;
  logic             exp_ok;
  logic             slot_bad;
  logic             is_run;
  logic             is_chk;

  assign is_run = (state == S_RUN);
  assign is_chk = (state == S_CHECK);

  // Only full-word stores count, both for capture and for the flag.
  assign full = (bus.d_mem_wen == 4'b1111);
  assign off  = bus.d_mem_addr - BASE;
  assign slot = off[IDX_W+1:2];

  assign in_win = full
               && (bus.d_mem_addr >= BASE)
               && (off < SPAN)
               && (off[1:0] == 2'b00);

  assign done_st = full
                && (bus.d_mem_addr == DADDR)
                && (bus.d_mem_wdata == DONE_VALUE);

  assign to_hit = (cyc_cnt == TO_LAST);
  assign exp_ok = exp_wr_en && ({1'b0, exp_wr_idx} < NUM);

  assign slot_bad = !mask[chk_idx]
                 || (res[chk_idx] != expv[chk_idx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN: begin
        if (done_st || to_hit) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (chk_idx == LAST) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_DONE;
      end
      default: begin
        state_nx = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        res[i]  <= '0;
        expv[i] <= '0;
      end
      mask    <= '0;
      chk_idx <= '0;
      fails   <= '0;
      first   <= '0;
      to_flag <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      if (is_run) begin
        if (cyc_cnt != '1) begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
        if (in_win) begin
          res[slot]  <= bus.d_mem_wdata;
          mask[slot] <= 1'b1;
        end
        if (exp_ok) begin
          expv[exp_wr_idx] <= exp_wr_data;
        end
        // A flag store on the timeout edge still counts as a clean finish.
        if (to_hit && !done_st) begin
          to_flag <= 1'b1;
        end
      end
      if (is_chk) begin
        chk_idx <= chk_idx + 1'b1;
        if (slot_bad) begin
          fails <= fails + 1'b1;
          if (fails == '0) begin
            first <= chk_idx;
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < NUM) begin
      rd_data = res[rd_idx];
    end
  end

  assign captured_mask  = mask;
  assign busy           = (state != S_DONE);
  assign done           = (state == S_DONE);
  assign pass           = done && (fails == '0) && !to_flag;
  assign timeout        = to_flag;
  assign fail_count     = fails;
  assign first_fail_idx = first;
  assign cycle_count    = cyc_cnt;

endmodule

// File: tb/tb_dmem_result_monitor.sv
// Randomized scoreboard bench for dmem_result_monitor.
// A result-window model predicts each run's verdict.
module tb_dmem_result_monitor;

  localparam int NUM = 6;
  localparam int TO  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exp_wr_en;
  logic [2:0]  exp_wr_idx;
  logic [31:0] exp_wr_data;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic [5:0]  captured_mask;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [3:0]  fail_count;
  logic [2:0]  first_fail_idx;
  logic [31:0] cycle_count;

  dmem_result_monitor_if bus();

  always #5 clk = ~clk;

  dmem_result_monitor #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .exp_wr_en(exp_wr_en),
    .exp_wr_idx(exp_wr_idx),
    .exp_wr_data(exp_wr_data),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .captured_mask(captured_mask),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_count(fail_count),
    .first_fail_idx(first_fail_idx),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic        pass;
    logic [3:0]  fails;
    logic [2:0]  first;
    logic        to;
    logic [31:0] cycles;
    logic [5:0]  mask;
    int          done_cyc;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_res [NUM];
  logic [31:0] m_exp [NUM];
  logic [5:0]  m_cap;
  int          run_edges;
  bit          m_run;

  logic [31:0] nom [NUM];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model_finish(input bit to_f, input int dcyc);
    exp_t e;
    int nf = 0;
    int ff = 0;
    for (int i = 0; i < NUM; i++) begin
      if (!m_cap[i] || m_res[i] != m_exp[i]) begin
        if (nf == 0) ff = i;
        nf++;
      end
    end
    e.pass     = (nf == 0) && !to_f;
    e.fails    = 4'(nf);
    e.first    = 3'(ff);
    e.to       = to_f;
    e.cycles   = 32'(run_edges);
    e.mask     = m_cap;
    e.done_cyc = dcyc;
    q.push_back(e);
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic ee,
                       input logic [2:0] ei, input logic [31:0] ed);
    int s;
    @(negedge clk);
    rst_n = 1'b1;
    bus.d_mem_addr  = a;
    bus.d_mem_wdata = d;
    bus.d_mem_wen   = w;
    exp_wr_en   = ee;
    exp_wr_idx  = ei;
    exp_wr_data = ed;
    if (m_run) begin
      run_edges++;
      if (w == 4'hF && a >= 512 && a < 512 + 4 * NUM && a[1:0] == 2'b00) begin
        s = int'((a - 512) / 4);
        m_res[s] = d;
        m_cap[s] = 1'b1;
      end
      if (ee && int'(ei) < NUM) m_exp[ei] = ed;
      if (w == 4'hF && a == 768 && d == 1) begin
        m_run = 0;
        model_finish(0, cyc + 1 + NUM);
      end else if (run_edges == TO) begin
        m_run = 0;
        model_finish(1, cyc + 1 + NUM);
      end
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 4'hF, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic ld(input logic [2:0] i, input logic [31:0] v);
    drive(32'd0, 32'd0, 4'h0, 1'b1, i, v);
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 4'h0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    bus.d_mem_addr  = 32'd512;
    bus.d_mem_wdata = 32'd9;
    bus.d_mem_wen   = 4'hF;
    exp_wr_en   = 1'b1;
    exp_wr_idx  = 3'($urandom_range(0, 5));
    exp_wr_data = $urandom;
    rd_idx      = 3'($urandom_range(0, 5));
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_first_fail", first_fail_idx, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_mask", captured_mask, 0);
    chk("rst_rd_data", rd_data, 0);
    for (int i = 0; i < NUM; i++) begin
      m_res[i] = '0;
      m_exp[i] = '0;
    end
    m_cap = '0;
    run_edges = 0;
    m_run = 1;
    q.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      idle();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait actual=busy required=done");
      q.delete();
    end
  endtask

  task automatic readback();
    for (int i = 0; i < NUM; i++) begin
      @(negedge clk);
      rd_idx = 3'(i);
      #1;
      chk("rd_data", rd_data, m_res[i]);
    end
  endtask

  task automatic load_all(input logic [31:0] v [NUM]);
    for (int i = 0; i < NUM; i++) ld(3'(i), v[i]);
  endtask

  task automatic store_all(input logic [31:0] v [NUM]);
    int ord [NUM];
    int j;
    int t;
    for (int i = 0; i < NUM; i++) ord[i] = i;
    for (int i = NUM - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    for (int i = 0; i < NUM; i++) begin
      st(32'(512 + 4 * ord[i]), v[ord[i]]);
      if ($urandom_range(0, 2) == 0) idle();
    end
  endtask

  bit seen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !done) begin
      seen = 0;
    end else if (!seen) begin
      seen = 1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=busy");
      end else begin
        e = q.pop_front();
        chk("mon_done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("mon_busy", busy, 0);
        chk("mon_pass", pass, e.pass);
        chk("mon_fail_count", fail_count, e.fails);
        chk("mon_first_fail", first_fail_idx, e.first);
        chk("mon_timeout", timeout, e.to);
        chk("mon_cycle_count", cycle_count, e.cycles);
        chk("mon_mask", captured_mask, e.mask);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v [NUM];
    int op;
    bus.d_mem_addr  = '0;
    bus.d_mem_wdata = '0;
    bus.d_mem_wen   = '0;
    exp_wr_en   = 1'b0;
    exp_wr_idx  = '0;
    exp_wr_data = '0;
    rd_idx      = '0;
    nom[0] = 32'd5;
    nom[1] = 32'hA;
    nom[2] = 32'hF;
    nom[3] = 32'd5;
    nom[4] = 32'h2A;
    nom[5] = 32'hFFFF_FFF9;
    repeat (2) @(negedge clk);

    // nominal
    reset_dut();
    load_all(nom);
    store_all(nom);
    st(32'd768, 32'd1);
    wait_done();
    readback();

    // mismatch
    reset_dut();
    load_all(nom);
    v = nom;
    v[2] = 32'h10;
    v[5] = 32'h0;
    store_all(v);
    st(32'd768, 32'd1);
    wait_done();
    readback();

    // missing slot 1, partial and misaligned stores to slot 0
    reset_dut();
    load_all(nom);
    drive(32'd512, nom[0], 4'b0011, 1'b0, 3'd0, 32'd0);
    st(32'd514, nom[0]);
    for (int i = 2; i < NUM; i++) st(32'(512 + 4 * i), nom[i]);
    st(32'd768, 32'd1);
    wait_done();
    readback();

    // wrong flag value, overwrite
    reset_dut();
    load_all(nom);
    st(32'd768, 32'd2);
    idle();
    idle();
    chk("flag2_busy", busy, 1);
    chk("flag2_done", done, 0);
    st(32'd512, 32'd7);
    st(32'd512, 32'd5);
    for (int i = 1; i < NUM; i++) st(32'(512 + 4 * i), nom[i]);
    st(32'd768, 32'd1);
    wait_done();
    readback();

    // timeout with all results correct
    reset_dut();
    load_all(nom);
    store_all(nom);
    for (int n = 0; n < 100 && m_run; n++) idle();
    wait_done();

    // flag store on the timeout edge
    reset_dut();
    load_all(nom);
    store_all(nom);
    while (m_run && run_edges < TO - 1) idle();
    st(32'd768, 32'd1);
    wait_done();

    // reset mid-CHECK, then zero rerun without expected loads
    reset_dut();
    load_all(nom);
    store_all(nom);
    st(32'd768, 32'd1);
    idle();
    idle();
    reset_dut();
    for (int i = 0; i < NUM; i++) v[i] = 32'd0;
    store_all(v);
    st(32'd768, 32'd1);
    wait_done();

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      reset_dut();
      for (int k = 0; k < 30; k++) begin
        op = $urandom_range(0, 5);
        case (op)
          0: ld(3'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
          1, 2: st(32'(512 + 4 * $urandom_range(0, NUM - 1)),
                   32'($urandom_range(0, 3)));
          3: st(32'(512 + $urandom_range(0, 40)), 32'($urandom_range(0, 3)));
          4: drive(32'(512 + 4 * $urandom_range(0, NUM - 1)),
                   32'($urandom_range(0, 3)), 4'($urandom_range(0, 14)),
                   1'b0, 3'd0, 32'd0);
          default: st(32'd768, 32'($urandom_range(2, 9)));
        endcase
      end
      if ($urandom_range(0, 3) != 0) st(32'd768, 32'd1);
      for (int k = 0; k < 4; k++) begin
        st(32'(512 + 4 * $urandom_range(0, NUM - 1)), $urandom);
        ld(3'($urandom_range(0, 5)), $urandom);
      end
      for (int n = 0; n < 100 && m_run; n++) idle();
      wait_done();
      readback();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_result_monitor.md
Name: dmem_result_monitor

Overview:
- Synthesizable self-check block on the CPU data-memory write port (d_mem_addr/d_mem_wdata/d_mem_wen), downstream of cpu_top.
- Snoops word stores into a result window and waits for the completion-flag store.
- Then compares the captured results against preloaded expected values and reports pass/fail, fail count and cycle count.
- Replaces ad-hoc bench-side result readback for the program tests.

Parameters:
RESULT_BASE, 512, byte address of result word 0
NUM_RESULTS, 6, number of result words captured/checked (1..2^IDX_W)
IDX_W, 3, index width, must satisfy 2^IDX_W >= NUM_RESULTS
DONE_ADDR, 768, byte address of completion flag
DONE_VALUE, 32'h1, flag value that ends the run
TIMEOUT_CYCLES, 10000, RUN-state cycles before forced timeout
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
d_mem_addr  in  32  CPU data address
d_mem_wdata  in  32  CPU store data
d_mem_wen  in  4  CPU byte write enables
exp_wr_en  in  1  load one expected value
exp_wr_idx  in  IDX_W  expected-value slot
exp_wr_data  in  32  expected value
rd_idx  in  IDX_W  captured-result read index
rd_data  out  32  captured result[rd_idx], combinational
captured_mask  out  NUM_RESULTS  bit i set once slot i has been written
busy  out  1  high in RUN and CHECK
done  out  1  check finished
pass  out  1  all slots match and no timeout; valid when done
timeout  out  1  run ended by timeout
fail_count  out  IDX_W+1  number of mismatching slots
first_fail_idx  out  IDX_W  lowest mismatching slot; 0 if none
cycle_count  out  CNT_W  clock edges spent in RUN

Behaviour:
- Reset (rst_n low at posedge):
  - state=RUN.
  - All result and expected slots = 0; captured_mask = 0.
  - busy=1; done, pass, timeout = 0; fail_count, first_fail_idx, cycle_count = 0.
  - exp_wr_en is ignored while rst_n is low.
- Qualified store: d_mem_wen==4'b1111. Partial-byte stores are never captured and never count as a done store.
- RUN:
  - cycle_count increments on every edge in RUN, including the exit edge.
  - Result capture: on a qualified store with RESULT_BASE <= addr < RESULT_BASE+4*NUM_RESULTS and addr[1:0]==0, slot (addr-RESULT_BASE)>>2 = wdata and its captured_mask bit is set. A repeat store to the same slot overwrites it (last store wins).
  - Misaligned or out-of-window stores are ignored.
  - exp_wr_en with exp_wr_idx < NUM_RESULTS writes the expected slot. Out-of-range indices and loads outside RUN are ignored.
  - Done store: qualified store, addr==DONE_ADDR, wdata==DONE_VALUE → state CHECK next edge. Any other value at DONE_ADDR is ignored.
  - Timeout: at an edge where cycle_count==TIMEOUT_CYCLES-1 and no done store is present → timeout=1, state CHECK.
  - A done store and the timeout condition on the same edge → done store wins, timeout stays 0.
- CHECK:
  - Internal index i runs 0..NUM_RESULTS-1, one slot per cycle.
  - Slot i fails if its captured_mask bit is 0 or result[i] != expected[i].
  - Each failure increments fail_count; the first failure loads first_fail_idx.
  - Bus stores are ignored; cycle_count frozen.
  - The edge that evaluates the last slot moves the state to DONE.
- DONE:
  - done=1, busy=0, pass=(fail_count==0 && !timeout). Held until reset.
  - Stores ignored.
- Latency: done store sampled at edge k → CHECK at k+1..k+NUM_RESULTS → done and pass high after edge k+NUM_RESULTS (NUM_RESULTS+1 edges after the store).
- Timeout with all results correct still gives pass=0 and fail_count=0.
- Reset mid-RUN or mid-CHECK fully clears state, including expected values; the bench reloads expected values after reset.
- cycle_count saturates at all-ones; it never wraps.

Test Plan:
- Nominal: load expected 5, 0xA, 0xF, 5, 0x2A, 0xFFFFFFF9. Store the same values to 512..532, then 1 to 768 → done 7 edges after the flag store, pass=1, fail_count=0, captured_mask=6'b111111.
- Mismatch: as nominal but store 0x10 to 520 and 0 to 532 → pass=0, fail_count=2, first_fail_idx=2, rd_idx=2 gives rd_data=0x10.
- Missing and filtered stores: omit the store to 516, store wen=4'b0011 to 512, store to 514 (misaligned) → slot 0 and slot 1 fail, fail_count=2, first_fail_idx=0, captured_mask bit1=0.
- Flag value and overwrite: store 2 to 768 → still busy; store 7 then 5 to 512 → slot 0=5; then store 1 to 768 → done.
- Timeout: TIMEOUT_CYCLES=50, no flag store → timeout=1, cycle_count=50, pass=0. Flag store on the same edge as the timeout condition → timeout=0.
- Reset mid-CHECK: assert rst_n=0 for one edge during CHECK → all outputs at reset values, busy=1, expected slots read back as 0 (observed via fail_count after a zero-result rerun: pass=1 only with all-zero stores).
